sevenseg_mux_driver: RTL and testbench
======================================

Name: sevenseg_mux_driver

Overview:
- Transmit side of the two-digit multiplexed seven-segment interface.
- Takes an 8-bit hex value and drives active-low segment codes for the high and low nibble on one shared segment bus, with a digit-select line alternating at a programmable refresh rate.
- Output is directly checkable by the existing seven-segment demultiplexer: segsel=1 means high digit, segsel=0 means low digit.
- New values are applied only at frame boundaries, so a displayed frame never mixes old and new nibbles.

Parameters:
- REFRESH_DIV, 12000: clock cycles each digit is held. Must be >= 2.
- CNT_W, 16: refresh counter width. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk, input, 1: single system clock. All logic is on its rising edge.
- resetn, input, 1: synchronous, active-low reset.
- value, input, 8: hex value to display. [7:4] is the high digit, [3:0] is the low digit.
- load, input, 1: one-cycle strobe that captures value into the pending register.
- enable, input, 1: 1 = display active; 0 = blanked.
- segval, output, 7: active-low segment code, registered.
- segsel, output, 1: digit select, registered. 1 = high digit, 0 = low digit.
- pending, output, 1: a loaded value is waiting for the next frame boundary.
- frame_tick, output, 1: one-cycle pulse marking the first cycle of a new frame.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - segval=7'h7F (blank), segsel=1, pending=0, frame_tick=0.
  - Internal: shown=8'h00, pend_val=8'h00, cnt=0.
- Segment encoding (active low, bit order g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E
  - Blank = 7F. The receiver flags 7F as an error; this is expected while blanked.
- Load capture: load=1 at an edge sets pend_val<=value and pending<=1 regardless of enable. A second load before the boundary overwrites pend_val (last wins).
- Sequencer states: HI (segsel=1) and LO (segsel=0). cnt counts 0..REFRESH_DIV-1 in each state.
  - At cnt==REFRESH_DIV-1: cnt<=0, state toggles, and segval/segsel update on the same edge. No dead cycle and no glitch between the two outputs.
- Frame boundary = the LO->HI edge, or the first enabled edge after enable rises, or the first edge after reset with enable=1.
  - If pending=1: shown<=pend_val and pending<=0.
  - The HI code driven on that edge uses the new value (bypass from pend_val).
  - frame_tick=1 for the following cycle only.
- load in the same cycle as a boundary: the old pend_val is committed to shown, the new value goes to pend_val, and pending stays 1.
- Steady state:
  - HI: segval=enc(shown[7:4]).
  - LO: segval=enc(shown[3:0]).
- Disable: enable=0 at an edge gives segval<=7F, segsel<=1, cnt<=0, state<=HI, and frame_tick=0. shown is unchanged; pending keeps accepting loads.
- Re-enable: the first edge with enable=1 is a frame boundary.
- Reset mid-frame: all state returns to reset values on the next edge. A pending value is discarded.
- Latency: a load at edge N with the sequencer in LO at count k is displayed at edge N+(REFRESH_DIV-1-k)+1 (the next LO->HI edge).

Decomposition:
- Package sevenseg_pkg holds:
  - The 16 segment-code constants SEG_0..SEG_F and SEG_BLANK=7'h7F.
  - A digit-state typedef (HI, LO).
- Combinational sub-module hex_to_seg: 4-bit nibble in, 7-bit active-low code out. Instantiated once, fed by a mux that selects the nibble for the next state.
- Counter, state, pending logic and output registers live in the top module.

Test Plan:
- Use REFRESH_DIV=4 for all scenarios.
1. Reset, then enable=1, no load -> from the first edge, segval=40 for 4 cycles with segsel=1, then 40 for 4 cycles with segsel=0, repeating. frame_tick pulses every 8 cycles. segconverter gives Hi=0, Lo=0, error=0.
2. load value=8'hA7 mid-HI -> pending=1 until the next LO->HI edge. Then segval=08 with segsel=1, followed by 78 with segsel=0. pending returns to 0 and frame_tick pulses. The same frame never shows 08 and 40.
3. Two loads before the boundary, 8'h12 then 8'h3C -> only 8'h3C appears: segval=30 (hi), then 46 (lo). 8'h12 is never displayed.
4. load 8'hE5 in the exact boundary cycle while pending holds 8'h9B -> the next frame shows 10/03. The following frame shows 06/12.
5. enable=0 for 10 cycles -> segval=7F and segsel=1 throughout. A load of 8'hF0 during this time sets pending. After re-enable, the first edge gives segval=0E (hi), then 40 (lo) 4 cycles later.
6. resetn=0 for one edge mid-LO with pending=1 -> next cycle segval=7F, segsel=1, pending=0. After reset, shown=00 is displayed (40/40).

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the two-digit
// multiplexed seven-segment transmit path.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    HI = 1'b0,
    LO = 1'b1
  } dig_t;

endpackage

// File: rtl/hex_to_seg.sv
// Nibble to active-low seven-segment code,
// bit order g..a.
module hex_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Full 16-entry lookup; blank only as default.
  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Two-digit multiplexed seven-segment driver;
// new values commit only at frame boundaries.
module sevenseg_mux_driver
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 12000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       enable,
  output logic [6:0] segval,
  output logic       segsel,
  output logic       pending,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(REFRESH_DIV - 1);

  dig_t             state;
  dig_t             state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [7:0]       shown;
  logic [7:0]       shown_nx;
  logic [7:0]       pend_val;
  logic             live;
  logic             wrap;
  logic             bound;
  logic [3:0]       nib;
  logic [6:0]       code;

  // Next state, boundary detect and nibble for
  // the state being entered (bypasses pend_val).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    shown_nx = shown;
    bound    = 1'b0;
    wrap     = (cnt == LAST);
    if (!enable) begin
      state_nx = HI;
      cnt_nx   = '0;
    end else if (!live ||
                 (wrap && state == LO)) begin
      bound    = 1'b1;
      state_nx = HI;
      cnt_nx   = '0;
      if (pending) shown_nx = pend_val;
    end else if (wrap) begin
      state_nx = LO;
      cnt_nx   = '0;
    end
    nib = (state_nx == HI) ? shown_nx[7:4]
                           : shown_nx[3:0];
  end

  hex_to_seg u_enc (
    .nib (nib),
    .seg (code)
  );

  // Sequencer state, counter, enable history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= HI;
      cnt   <= '0;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      live  <= enable;
    end
  end

  // Value capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shown      <= 8'h00;
      pend_val   <= 8'h00;
      pending    <= 1'b0;
      segval     <= SEG_BLANK;
      segsel     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      shown <= shown_nx;
      if (load) begin
        pend_val <= value;
        pending  <= 1'b1;
      end else if (bound) begin
        pending  <= 1'b0;
      end
      segval     <= enable ? code : SEG_BLANK;
      segsel     <= (state_nx == HI);
      frame_tick <= bound;
    end
  end

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Directed bench for sevenseg_mux_driver
// with REFRESH_DIV=4.
module tb_sevenseg_mux_driver;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] value;
  logic       load;
  logic       enable;
  logic [6:0] segval;
  logic       segsel;
  logic       pending;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  sevenseg_mux_driver #(
    .REFRESH_DIV (4),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .value      (value),
    .load       (load),
    .enable     (enable),
    .segval     (segval),
    .segsel     (segsel),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(
    input string      tag,
    input logic [6:0] sv,
    input logic       ss,
    input logic       pd,
    input logic       ft
  );
    check({tag, ".segval"}, 32'(segval), 32'(sv));
    check({tag, ".segsel"}, 32'(segsel), 32'(ss));
    check({tag, ".pend"}, 32'(pending), 32'(pd));
    check({tag, ".tick"}, 32'(frame_tick), 32'(ft));
  endtask

  // One 8-cycle frame starting on its boundary
  // edge; p0 is pending right after that edge,
  // and up to two loads land at cycles a1/a2.
  task automatic frame(
    input string      tag,
    input logic [6:0] hi,
    input logic [6:0] lo,
    input logic       p0,
    input int         a1,
    input logic [7:0] v1,
    input int         a2,
    input logic [7:0] v2
  );
    logic pd;
    pd = p0;
    for (int i = 0; i < 8; i++) begin
      if (i == a1) begin
        load = 1'b1; value = v1;
      end
      if (i == a2) begin
        load = 1'b1; value = v2;
      end
      tick();
      load = 1'b0;
      if (i == a1 || i == a2) pd = 1'b1;
      outs($sformatf("%s[%0d]", tag, i),
           (i < 4) ? hi : lo, i < 4, pd, i == 0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    value  = 8'h00;
    tick();
    tick();
    outs("rst", 7'h7F, 1'b1, 1'b0, 1'b0);

    resetn = 1'b1;
    enable = 1'b1;
    frame("t1a", 7'h40, 7'h40, 0, -1, 0, -1, 0);
    frame("t1b", 7'h40, 7'h40, 0, -1, 0, -1, 0);

    frame("t2a", 7'h40, 7'h40, 0,
          2, 8'hA7, -1, 0);
    frame("t2b", 7'h08, 7'h78, 0, -1, 0, -1, 0);

    frame("t3a", 7'h08, 7'h78, 0,
          1, 8'h12, 5, 8'h3C);
    frame("t3b", 7'h30, 7'h46, 0,
          3, 8'h9B, -1, 0);

    frame("t4a", 7'h10, 7'h03, 1,
          0, 8'hE5, -1, 0);
    frame("t4b", 7'h06, 7'h12, 0, -1, 0, -1, 0);

    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        load = 1'b1; value = 8'hF0;
      end
      tick();
      load = 1'b0;
      outs($sformatf("t5off[%0d]", i),
           7'h7F, 1'b1, i >= 3, 1'b0);
    end
    enable = 1'b1;
    frame("t5on", 7'h0E, 7'h40, 0, -1, 0, -1, 0);

    for (int i = 0; i < 5; i++) tick();
    check("t6.presel", 32'(segsel), 32'd0);
    load  = 1'b1;
    value = 8'h55;
    tick();
    load  = 1'b0;
    check("t6.prepend", 32'(pending), 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    outs("t6rst", 7'h7F, 1'b1, 1'b0, 1'b0);
    frame("t6a", 7'h40, 7'h40, 0, -1, 0, -1, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
